// File: rtl/pb_port_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pb_port_master_pkg
//  Purpose  : Shared types and constants for the PicoBlaze port bus master.
//  Revision : 1.0  initial release
// ============================================================================
package pb_port_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } pb_state_e;

    localparam int unsigned c_cnt_w        = 3;
    localparam logic [7:0]  c_port_id_rst  = 8'h00;
    localparam logic [7:0]  c_data_out_rst = 8'h00;

endpackage : pb_port_master_pkg
`default_nettype wire

// File: rtl/pb_irq_catch.sv
`default_nettype none
// ============================================================================
//  Module   : pb_irq_catch
//  Purpose  : Synchronises the peripheral interrupt, latches its rising edge
//             and returns a one-cycle interrupt_ack when the host acknowledges.
//  Revision : 1.0  initial release
// ============================================================================
module pb_irq_catch (
    input  logic clk,
    input  logic rst,
    input  logic i_interrupt,
    input  logic i_irq_ack,
    output logic o_irq_pending,
    output logic o_interrupt_ack
);

    logic [1:0] r_sync;
    logic       r_sync_d;
    logic       r_pending;
    logic       r_ack;
    logic       w_rise;
    logic       w_ack_take;

    assign w_rise     = r_sync[1] & ~r_sync_d;
    assign w_ack_take = i_irq_ack & r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_sync_d  <= 1'b0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_interrupt};
            r_sync_d  <= r_sync[1];
            // A fresh edge outranks a simultaneous acknowledge.
            r_pending <= w_rise | (r_pending & ~w_ack_take);
            r_ack     <= w_ack_take;
        end
    end

    assign o_irq_pending   = r_pending;
    assign o_interrupt_ack = r_ack;

endmodule : pb_irq_catch
`default_nettype wire

// File: rtl/pb_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : pb_port_master
//  Purpose  : Turns host request/response transfers into KCPSM-style
//             port_id/strobe cycles and relays the peripheral interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module pb_port_master
    import pb_port_master_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [7:0] port_id,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic       interrupt,
    output logic       irq_pending,
    input  logic       irq_ack,
    output logic       interrupt_ack
);

    localparam logic [c_cnt_w-1:0] c_setup_load = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load  =
        (HOLD_CYCLES == 0) ? '0 : c_cnt_w'(HOLD_CYCLES - 1);
    localparam bit c_has_hold = (HOLD_CYCLES != 0);

    pb_state_e            r_state;
    pb_state_e            w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_accept;
    logic                 r_write;
    logic [7:0]           r_port_id;
    logic [7:0]           r_data_out;
    logic [7:0]           r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_port_id   <= c_port_id_rst;
            r_data_out  <= c_data_out_rst;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write     <= req_write;
                r_port_id   <= req_addr;
                r_data_out  <= req_wdata;
                r_rsp_rdata <= 8'h00;
            end
            // Read data is only guaranteed valid while read_strobe is high.
            if (r_state == ST_STROBE && !r_write) begin
                r_rsp_rdata <= data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_setup_load;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) w_state_nxt = ST_STROBE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_STROBE: begin
                if (c_has_hold) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_hold_load;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) w_state_nxt = ST_RESP;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_rdata    = r_rsp_rdata;
    assign port_id      = r_port_id;
    assign data_out     = r_data_out;
    assign write_strobe = (r_state == ST_STROBE) &&  r_write;
    assign read_strobe  = (r_state == ST_STROBE) && !r_write;

    pb_irq_catch u_irq_catch (
        .clk             (clk),
        .rst             (reset),
        .i_interrupt     (interrupt),
        .i_irq_ack       (irq_ack),
        .o_irq_pending   (irq_pending),
        .o_interrupt_ack (interrupt_ack)
    );

endmodule : pb_port_master
`default_nettype wire
